// File: rtl/tx.sv
// Parameterised UART-style serial transmitter: start bit, LSB-first data, optional
// parity, one or two stop bits. All outputs are registered.
module tx #(
   parameter int unsigned CLK_BAUD_RATIO = 2,
   parameter int unsigned DATA_SIZE      = 8,
   parameter int unsigned PARITY         = 0,
   parameter int unsigned STOP_BITS      = 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 new_data_in,
   input  logic [DATA_SIZE-1:0] data_in,
   output logic                 tx_out,
   output logic                 busy_out
);

   localparam int unsigned CNT_W = (CLK_BAUD_RATIO > 1) ? $clog2(CLK_BAUD_RATIO) : 1;
   localparam int unsigned BIT_W = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_SIZE-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 cnt_wrap;

   assign cnt_wrap = (cnt_q == CNT_W'(CLK_BAUD_RATIO - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;

      if (state_q != StIdle) begin
         cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (new_data_in) begin
               state_d = StStart;
               shift_d = data_in;
               par_d   = (PARITY == 2) ? ~(^data_in) : ^data_in;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         StStart: begin
            if (cnt_wrap) begin
               state_d = StData;
               bit_d   = '0;
            end
         end
         StData: begin
            if (cnt_wrap) begin
               if (bit_q == BIT_W'(DATA_SIZE - 1)) begin
                  state_d = (PARITY != 0) ? StParity : StStop;
                  bit_d   = '0;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end
         end
         StParity: begin
            if (cnt_wrap) begin
               state_d = StStop;
               bit_d   = '0;
            end
         end
         StStop: begin
            // bit_q doubles as the stop-bit index
            if (cnt_wrap) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  state_d = StIdle;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs follow the next state so the line changes on the same edge as the state.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StIdle:   tx_d = 1'b1;
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         StStop:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign tx_out   = tx_q;
   assign busy_out = busy_q;

endmodule

// File: tb/tb_tx.sv
// Directed bench for tx: four instances cover no-parity, even, odd/two-stop and
// one-cycle-per-bit configurations, driven from shared stimulus.
module tb_tx;

   logic       clk;
   logic       rst;
   logic       new_data;
   logic [7:0] data;
   logic [3:0] tx_w;
   logic [3:0] busy_w;
   int         sel;
   int         checks;
   int         failures;

   tx #(.CLK_BAUD_RATIO(2), .DATA_SIZE(4), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk_in(clk), .rst_in(rst), .new_data_in(new_data), .data_in(data[3:0]),
      .tx_out(tx_w[0]), .busy_out(busy_w[0]));
   tx #(.CLK_BAUD_RATIO(2), .DATA_SIZE(8), .PARITY(1), .STOP_BITS(1)) u1 (
      .clk_in(clk), .rst_in(rst), .new_data_in(new_data), .data_in(data),
      .tx_out(tx_w[1]), .busy_out(busy_w[1]));
   tx #(.CLK_BAUD_RATIO(2), .DATA_SIZE(8), .PARITY(2), .STOP_BITS(2)) u2 (
      .clk_in(clk), .rst_in(rst), .new_data_in(new_data), .data_in(data),
      .tx_out(tx_w[2]), .busy_out(busy_w[2]));
   tx #(.CLK_BAUD_RATIO(1), .DATA_SIZE(8), .PARITY(1), .STOP_BITS(1)) u3 (
      .clk_in(clk), .rst_in(rst), .new_data_in(new_data), .data_in(data),
      .tx_out(tx_w[3]), .busy_out(busy_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic exp_tx, input logic exp_busy);
      checks++;
      assert (tx_w[sel] === exp_tx) else begin
         failures++;
         $error("FAIL %s u%0d tx observed=%b expected=%b", tag, sel, tx_w[sel], exp_tx);
      end
      checks++;
      assert (busy_w[sel] === exp_busy) else begin
         failures++;
         $error("FAIL %s u%0d busy observed=%b expected=%b", tag, sel, busy_w[sel], exp_busy);
      end
   endtask

   task automatic do_reset(input string tag);
      rst      = 1'b0;
      new_data = 1'b0;
      tick();
      check(tag, 1'b1, 1'b0);
      rst = 1'b1;
   endtask

   // bits[i] is the value of bit period i (start first); first tick is the acceptance edge.
   task automatic run_frame(input string tag, input int nbits, input logic [15:0] bits,
                            input int ratio, input bit hold, input bit mess);
      for (int i = 0; i < nbits; i++) begin
         for (int r = 0; r < ratio; r++) begin
            tick();
            check(tag, bits[i], 1'b1);
            if (!hold) new_data = 1'b0;
            if (mess && i == 3 && r == 0) begin
               new_data = 1'b1;
               data     = ~data;
            end
            if (mess && i == 3 && r == 1) new_data = 1'b0;
         end
      end
   endtask

   task automatic idle_check(input string tag);
      tick();
      check(tag, 1'b1, 1'b0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      new_data = 1'b0;
      data     = 8'h00;

      // 4-bit, no parity, back-to-back frames with request held high
      sel = 0;
      do_reset("reset_u0");
      new_data = 1'b1;
      data     = 8'h06;
      run_frame("frame_0110", 6, 16'({1'b1, 4'b0110, 1'b0}), 2, 1'b1, 1'b0);
      idle_check("gap_0110");
      run_frame("frame_0110_rep", 6, 16'({1'b1, 4'b0110, 1'b0}), 2, 1'b1, 1'b0);
      idle_check("gap_0110_rep");
      // mid-frame request and data change are ignored
      run_frame("frame_ignore_req", 6, 16'({1'b1, 4'b0110, 1'b0}), 2, 1'b0, 1'b1);
      idle_check("idle_after_ignore0");
      idle_check("idle_after_ignore1");
      idle_check("idle_after_ignore2");

      // even parity, 0xA5
      sel = 1;
      do_reset("reset_u1");
      new_data = 1'b1;
      data     = 8'hA5;
      run_frame("frame_a5_even", 11, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 2, 1'b0, 1'b0);
      idle_check("idle_a5_even");

      // odd parity, two stop bits, 0x01
      sel = 2;
      do_reset("reset_u2");
      new_data = 1'b1;
      data     = 8'h01;
      run_frame("frame_01_odd", 12, 16'({2'b11, 1'b0, 8'h01, 1'b0}), 2, 1'b0, 1'b0);
      idle_check("idle_01_odd");

      // one clock per bit, even parity, 0x07
      sel = 3;
      do_reset("reset_u3");
      new_data = 1'b1;
      data     = 8'h07;
      run_frame("frame_07_r1", 11, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 1, 1'b0, 1'b0);
      idle_check("idle_07_r1");

      // reset during data bits aborts the frame, then a clean frame follows
      sel = 1;
      do_reset("reset_u1_abort");
      new_data = 1'b1;
      data     = 8'hFF;
      tick();
      check("abort_accept", 1'b0, 1'b1);
      new_data = 1'b0;
      tick();
      check("abort_start2", 1'b0, 1'b1);
      tick();
      check("abort_d0", 1'b1, 1'b1);
      tick();
      check("abort_d0b", 1'b1, 1'b1);
      rst = 1'b0;
      tick();
      check("abort_line_high", 1'b1, 1'b0);
      tick();
      check("abort_held", 1'b1, 1'b0);
      rst      = 1'b1;
      new_data = 1'b1;
      data     = 8'hA5;
      run_frame("frame_after_abort", 11, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 2, 1'b0, 1'b0);
      idle_check("idle_after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
